truth_table_capture: RTL
========================

# truth_table_capture

Hardware monitor that sits alongside a combinational DUT and records its observed truth table as the bench sweeps input vectors. It qualifies each input vector for stability, samples the DUT output once per stable window, tracks which vectors have been covered, and flags vectors that produced inconsistent outputs. A handshaked dump port then streams the captured table out, one entry per beat, for logging or comparison.

## Interface
- N_IN, default 3: number of DUT inputs; table depth is 2^N_IN.
- SETTLE_CYCLES, default 2: number of additional valid, unchanged cycles required before y is sampled.

- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- in_vec  in  N_IN  DUT input vector being driven; MSB corresponds to a, LSB to c when N_IN=3.
- in_valid  in  1  in_vec is being actively driven.
- y  in  1  DUT output.
- clear  in  1  one-cycle request to wipe the table.
- dump_start  in  1  one-cycle request to stream the table out.
- out_valid  out  1  dump beat valid.
- out_ready  in  1  consumer accepts beat.
- out_addr  out  N_IN  table index of current beat.
- out_y  out  1  captured y for out_addr.
- out_seen  out  1  entry has been sampled at least once.
- out_conflict  out  1  entry saw differing y values.
- seen_count  out  N_IN+1  number of distinct vectors sampled.
- covered  out  1  seen_count == 2^N_IN.
- conflict_any  out  1  OR of all conflict bits.
- dump_done  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- Storage: per entry seen, yv, conflict (3 x 2^N_IN flops); stability counter stab (saturating); previous vector register; ptr (N_IN bits).
- Stability: each cycle with in_valid=1 and in_vec equal to the previous cycle's in_vec (previous cycle also valid), stab increments, saturating at SETTLE_CYCLES+1. A change of vector or in_valid=0 resets stab to 0.
- Sample fires on exactly the cycle stab == SETTLE_CYCLES with in_valid=1, i.e. once per stable window, after SETTLE_CYCLES+1 consecutive valid cycles of the same vector. Holding longer causes no resample.
- On sample at index v: if !seen[v], then seen[v]<=1, yv[v]<=y, seen_count+1. Otherwise, if y != yv[v], then conflict[v]<=1 and yv is retained (first value wins).
- FSM states:
  - CAPTURE (reset state): sampling active.
  - DUMP: sampling disabled, and stab is held at 0.
- CAPTURE -> DUMP on dump_start, with ptr<=0. In DUMP, out_valid=1 and out_* reflect entry ptr. A beat transfers when out_valid && out_ready, then ptr+1. Transfer at ptr = 2^N_IN-1 -> CAPTURE, with dump_done pulsed on the following cycle.
- clear in CAPTURE zeroes seen, yv, conflict, seen_count, and stab.
- Priorities in CAPTURE: clear beats dump_start and beats a simultaneous sample.
- In DUMP, clear and dump_start are ignored.
- covered and conflict_any are combinational from registered state.

## Timing
- Reset values:
  - All outputs are 0.
  - All table bits, stab, ptr, and seen_count are 0.
  - State is CAPTURE.
- Latency:
  - Sample on edge N: seen_count, covered, and conflict_any reflect it after edge N.
  - dump_start sampled at edge N: out_valid=1 from edge N onward, with out_addr=0.
- out_* remain stable while out_valid && !out_ready.
- A full dump takes at least 2^N_IN cycles at out_ready=1. There are no bubbles between beats.
- ptr wraps only by leaving DUMP; there is no second pass.
- Reset asserted mid-dump: out_valid drops immediately (async), the table is cleared, and the dump does not resume.
- seen_count cannot exceed 2^N_IN; width N_IN+1 holds the full count.

## Test plan
- Reset: assert rst for 3 cycles with in_valid=1 -> all outputs 0, no sampling during reset.
- Full sweep (N_IN=3, SETTLE=2): vectors 0..7 each held 4 valid cycles, y=(a&b)|c -> seen_count=8, covered=1 after 8th sample, conflict_any=0. A subsequent dump yields out_y = 0,1,0,1,0,1,1,1.
- Glitch: vector 5 held 2 valid cycles, then changed -> no sample, seen[5]=0, seen_count unchanged. Held 3 cycles -> sampled once.
- Conflict: vector 3 sampled with y=1, vector 6 sampled, then vector 3 sampled with y=0 -> conflict_any=1, dumped entry 3 has out_y=1 and out_conflict=1, seen_count=2.
- Dump backpressure: out_ready pattern 1,0,0,1 repeating, with in_valid sweeping during dump -> beats addr 0..7 in order, each held while out_ready=0, one dump_done pulse, table unchanged by stimulus during dump. Also: clear and dump_start in the same cycle in CAPTURE -> table cleared, no dump.
- Reset mid-dump: rst at beat 3 -> out_valid=0 same cycle, seen_count=0, state CAPTURE. A new sweep then captures normally.

Source files
------------

// File: rtl/truth_table_capture_if.sv
// Dump port of truth_table_capture: one table entry per valid/ready beat.
interface truth_table_capture_if #(
  parameter int N_IN = 3
);
  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_addr;
  logic            out_y;
  logic            out_seen;
  logic            out_conflict;

  modport master (
    output out_valid, out_addr, out_y, out_seen, out_conflict,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_y, out_seen, out_conflict,
    output out_ready
  );
endinterface

// File: rtl/truth_table_capture.sv
// Records the observed truth table of a combinational DUT, sampling y once per
// stable input window, and streams the table out through a handshaked dump port.
module truth_table_capture #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_vec,
  input  logic                  in_valid,
  input  logic                  y,
  input  logic                  clear,
  input  logic                  dump_start,
  truth_table_capture_if.master dump,
  output logic [N_IN:0]         seen_count,
  output logic                  covered,
  output logic                  conflict_any,
  output logic                  dump_done
);
  localparam int DEPTH = 1 << N_IN;
  localparam int SW    = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SW-1:0]   STAB_HIT = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]   STAB_MAX = SW'(SETTLE_CYCLES + 1);
  localparam logic [N_IN-1:0] LAST     = N_IN'(DEPTH - 1);
  localparam logic [N_IN:0]   FULL     = (N_IN + 1)'(DEPTH);

  typedef enum logic {CAPTURE, DUMP} state_t;

  state_t          state;
  logic [DEPTH-1:0] seen;
  logic [DEPTH-1:0] yv;
  logic [DEPTH-1:0] conflict;
  logic [SW-1:0]   stab;
  logic [SW-1:0]   stab_next;
  logic [N_IN-1:0] prev_vec;
  logic            prev_valid;
  logic [N_IN-1:0] ptr;
  logic            out_valid_r;
  logic            same;
  logic            sample;
  logic            beat;

  // stab_next counts extra stable cycles; sampling keys off the updated count
  // so a vector held SETTLE_CYCLES+1 valid cycles is sampled on its last one.
  always_comb begin
    same      = in_valid && prev_valid && (in_vec == prev_vec);
    stab_next = '0;
    if (state == CAPTURE && !clear && same)
      stab_next = (stab == STAB_MAX) ? STAB_MAX : stab + SW'(1);
    sample = (state == CAPTURE) && !clear && in_valid && (stab_next == STAB_HIT);
    beat   = (state == DUMP) && dump.out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= CAPTURE;
      seen        <= '0;
      yv          <= '0;
      conflict    <= '0;
      seen_count  <= '0;
      stab        <= '0;
      prev_vec    <= '0;
      prev_valid  <= 1'b0;
      ptr         <= '0;
      out_valid_r <= 1'b0;
      dump_done   <= 1'b0;
    end else begin
      prev_vec   <= in_vec;
      prev_valid <= in_valid;
      stab       <= stab_next;
      dump_done  <= 1'b0;
      case (state)
        CAPTURE: begin
          if (clear) begin
            seen       <= '0;
            yv         <= '0;
            conflict   <= '0;
            seen_count <= '0;
          end else begin
            // First observed value is kept; later disagreements only flag.
            if (sample) begin
              if (!seen[in_vec]) begin
                seen[in_vec] <= 1'b1;
                yv[in_vec]   <= y;
                seen_count   <= seen_count + (N_IN + 1)'(1);
              end else if (y != yv[in_vec]) begin
                conflict[in_vec] <= 1'b1;
              end
            end
            if (dump_start) begin
              state       <= DUMP;
              ptr         <= '0;
              out_valid_r <= 1'b1;
            end
          end
        end
        DUMP: begin
          if (beat) begin
            if (ptr == LAST) begin
              state       <= CAPTURE;
              ptr         <= '0;
              out_valid_r <= 1'b0;
              dump_done   <= 1'b1;
            end else begin
              ptr <= ptr + N_IN'(1);
            end
          end
        end
      endcase
    end
  end

  assign dump.out_valid    = out_valid_r;
  assign dump.out_addr     = ptr;
  assign dump.out_y        = out_valid_r & yv[ptr];
  assign dump.out_seen     = out_valid_r & seen[ptr];
  assign dump.out_conflict = out_valid_r & conflict[ptr];

  assign covered      = (seen_count == FULL);
  assign conflict_any = |conflict;
endmodule
